// File: rtl/uart_pkg.sv
// uart_pkg: shared types and sizing helpers for the UART receive/transmit blocks.
// Rev 1.0
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  function automatic int num_words(input int W, input int BPW);
    return W / BPW;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: free-running modulo-CLOCKS_PER_PULSE counter with clear and wrap tick.
// Rev 1.0
`default_nettype none

module uart_baud_cnt import uart_pkg::*; #(
  parameter int CLOCKS_PER_PULSE = 20833,
  localparam int CW = cnt_w(CLOCKS_PER_PULSE)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_clear,
  output logic [CW-1:0] o_cnt,
  output logic          o_tick
);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(CLOCKS_PER_PULSE - 1));
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// uart_rx: UART receiver assembling W_OUT/BITS_PER_WORD words into one m_data beat.
// Optional input synchroniser: define UART_RX_SYNC_EN. Rev 1.0
`default_nettype none

module uart_rx import uart_pkg::*; #(
  parameter int CLOCKS_PER_PULSE = 20833,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE      = 13,
  parameter int W_OUT            = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  output logic [W_OUT-1:0] m_data,
  output logic             m_valid,
  output logic             frame_err
);

  localparam int NUM_WORDS = num_words(W_OUT, BITS_PER_WORD);
  localparam int NUM_STOP  = PACKET_SIZE - BITS_PER_WORD - 1;
  localparam int CW        = cnt_w(CLOCKS_PER_PULSE);
  localparam int BW        = (cnt_w(BITS_PER_WORD) > cnt_w(NUM_STOP)) ?
                             cnt_w(BITS_PER_WORD) : cnt_w(NUM_STOP);
  localparam int WW        = cnt_w(NUM_WORDS);
  localparam int HALF      = CLOCKS_PER_PULSE / 2 - 1;

  logic w_rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  assign w_rx_s = r_sync[1];
`else
  assign w_rx_s = rx;
`endif

  uart_rx_state_t     r_state;
  logic               r_prev;
  logic [BW-1:0]      r_bit_cnt;
  logic [WW-1:0]      r_word_cnt;
  logic [BITS_PER_WORD-1:0] r_shift;
  logic [W_OUT-1:0]   r_asm;
  logic [W_OUT-1:0]   w_asm_next;
  logic [CW-1:0]      w_cnt;
  logic               w_tick;
  logic               w_half;
  logic               w_clear;

  assign w_half  = (w_cnt == CW'(HALF));
  // Hold the baud counter at zero while idle; re-phase it to mid-bit once the start bit is confirmed.
  assign w_clear = (r_state == IDLE) || ((r_state == START) && w_half);

  uart_baud_cnt #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
  ) u_baud (
    .clk    (clk),
    .rstn   (rstn),
    .i_clear(w_clear),
    .o_cnt  (w_cnt),
    .o_tick (w_tick)
  );

  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[r_word_cnt*BITS_PER_WORD +: BITS_PER_WORD] = r_shift;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_prev     <= 1'b1;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_shift    <= '0;
      r_asm      <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      r_prev    <= w_rx_s;
      case (r_state)
        IDLE: begin
          r_bit_cnt <= '0;
          if (!w_rx_s && r_prev) r_state <= START;
        end
        START: begin
          if (w_half) r_state <= w_rx_s ? IDLE : DATA;
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= BITS_PER_WORD'({w_rx_s, r_shift} >> 1);
            if (r_bit_cnt == BW'(BITS_PER_WORD - 1)) begin
              r_bit_cnt <= '0;
              r_state   <= STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (!w_rx_s) begin
              frame_err  <= 1'b1;
              r_word_cnt <= '0;
              r_state    <= IDLE;
            end else if (r_bit_cnt == BW'(NUM_STOP - 1)) begin
              r_state <= IDLE;
              if (r_word_cnt == WW'(NUM_WORDS - 1)) begin
                m_data     <= w_asm_next;
                m_valid    <= 1'b1;
                r_word_cnt <= '0;
              end else begin
                r_asm      <= w_asm_next;
                r_word_cnt <= r_word_cnt + 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a timing/packing model of the receiver.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CPP   = 4;
  localparam int BPW   = 8;
  localparam int PS    = 13;
  localparam int W     = 16;
  localparam int NW    = W / BPW;
  localparam int NSTOP = PS - BPW - 1;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         rx = 1'b1;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         frame_err;

  uart_rx #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD   (BPW),
    .PACKET_SIZE     (PS),
    .W_OUT           (W)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx       (rx),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           t;
    logic [W-1:0] d;
  } ev_t;

  ev_t            vq[$];
  int             fq[$];
  logic [BPW-1:0] words[$];
  logic [W-1:0]   last_data = '0;
  bit             chk_en = 1'b0;
  int             n_cmp = 0;
  int             n_err = 0;
  int             n_valid = 0;
  int             n_ferr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Every cycle: pulses must occur exactly when the model schedules them, and m_data must hold.
  always @(negedge clk) begin : cmp
    bit ev;
    bit ef;
    if (chk_en) begin
      ev = (vq.size() > 0) && (vq[0].t == cyc);
      ef = (fq.size() > 0) && (fq[0] == cyc);
      if (ev) begin
        last_data = vq[0].d;
        void'(vq.pop_front());
      end
      if (ef) void'(fq.pop_front());
      check("m_valid", m_valid, ev);
      check("frame_err", frame_err, ef);
      check("m_data_hold", m_data, last_data);
      if (m_valid) n_valid++;
      if (frame_err) n_ferr++;
    end
  end

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; schedules the model's expectations from the frame timing rules.
  task automatic send_word(input logic [BPW-1:0] d, input logic [NSTOP-1:0] stop, input int gap);
    int  t0;
    int  bad;
    ev_t e;
    t0  = cyc + 1 + LAT;
    bad = -1;
    for (int j = 0; j < NSTOP; j++) if (!stop[j] && bad < 0) bad = j;
    if (bad >= 0) begin
      fq.push_back(t0 + CPP/2 + (BPW + 1 + bad) * CPP);
      words.delete();
    end else begin
      words.push_back(d);
      if (words.size() == NW) begin
        e.d = '0;
        for (int k = 0; k < NW; k++) e.d[k*BPW +: BPW] = words[k];
        e.t = t0 + CPP/2 + (PS - 1) * CPP;
        vq.push_back(e);
        words.delete();
      end
    end
    drive_bit(1'b0, CPP);
    for (int i = 0; i < BPW; i++) drive_bit(d[i], CPP);
    for (int j = 0; j < NSTOP; j++) drive_bit(stop[j], CPP);
    if (gap > 0) drive_bit(1'b1, gap);
  endtask

  task automatic send_packet(input logic [W-1:0] v, input int gap);
    for (int k = 0; k < NW; k++)
      send_word(v[k*BPW +: BPW], '1, (k == NW - 1) ? gap : 0);
  endtask

  initial begin
    logic [BPW-1:0]   d;
    logic [NSTOP-1:0] stop;
    int               gap;
    bit               err;

    repeat (3) @(negedge clk);
    check("reset_m_valid", m_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_m_data", m_data, '0);
    rstn = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    send_word(8'h3C, '1, 0);
    send_word(8'hA5, '1, 8);
    check("t1_data", m_data, 16'hA53C);
    check("t1_valids", n_valid, 1);

    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch_valids", n_valid, 1);
    send_packet(16'h1234, 8);
    check("t2_data", m_data, 16'h1234);
    check("t2_valids", n_valid, 2);

    send_word(8'h11, '1, 0);
    send_word(8'h22, 4'b1110, 8);
    check("t3_ferr", n_ferr, 1);
    check("t3_valids", n_valid, 2);
    send_packet(16'hBEEF, 8);
    check("t3_data", m_data, 16'hBEEF);

    drive_bit(1'b0, CPP);
    drive_bit(1'b1, CPP);
    drive_bit(1'b0, CPP);
    drive_bit(1'b1, CPP);
    chk_en = 1'b0;
    rstn = 1'b0;
    rx = 1'b1;
    vq.delete();
    fq.delete();
    words.delete();
    repeat (3) @(negedge clk);
    check("midrst_m_data", m_data, '0);
    check("midrst_m_valid", m_valid, 1'b0);
    rstn = 1'b1;
    last_data = '0;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    send_packet(16'h00FF, 8);
    check("t4_data", m_data, 16'h00FF);

    send_packet(16'h0001, 0);
    send_packet(16'hFFFF, 0);
    send_packet(16'h8000, 8);
    check("t5_data", m_data, 16'h8000);
    check("t5_valids", n_valid, 7);

    for (int n = 0; n < 40; n++) begin
      d    = BPW'($urandom);
      err  = ($urandom_range(0, 7) == 0);
      stop = '1;
      if (err) stop[$urandom_range(0, NSTOP - 1)] = 1'b0;
      gap  = err ? $urandom_range(1, 6) : $urandom_range(0, 6);
      send_word(d, stop, gap);
    end

    drive_bit(1'b1, 70);
    check("drain_valid_q", vq.size(), 0);
    check("drain_ferr_q", fq.size(), 0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
